uart_fifo: RTL and testbench

- Parametrised successor to the single-byte TX UART on the same 5-bit peripheral bus.
- Adds a TX FIFO, a runtime-programmable baud divisor, sticky error flags and a compile-time optional receiver with its own FIFO.
- Sits on the CPU peripheral bus: byte-wide register reads and writes, 1-cycle read response.

---
 rtl/uart_fifo_if.sv | 16 +
 rtl/uart_fifo.sv | 276 +++++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_if.sv
// Byte-wide peripheral register bus shared by the CPU (master) and uart_fifo (slave).
// Handshake: master pulses rd_en or wr_en for one cycle with addr (and wr_data);
// every read is answered on the following cycle by a one-cycle rd_valid pulse carrying rd_data.
interface uart_fifo_if;
  logic [4:0] addr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wr_en;
  logic [7:0] wr_data;

  modport master (output addr, output rd_en, output wr_en, output wr_data,
                  input  rd_data, input rd_valid);
  modport slave  (input  addr, input rd_en, input wr_en, input wr_data,
                  output rd_data, output rd_valid);
endinterface

// File: rtl/uart_fifo.sv
// UART with TX FIFO, programmable divisor and sticky error flags on the 5-bit register bus.
// Optional receiver with its own FIFO is compiled in when UART_RX_EN is defined.
module uart_fifo #(
  parameter int DIVIDER  = 7,
  parameter int DIV_W    = 13,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rstn,
  uart_fifo_if.slave bus,
  output logic       tx,
  input  logic       rx
);
  localparam int               TX_AW   = $clog2(TX_DEPTH);
  localparam logic [TX_AW:0]   TX_FULL = (TX_AW+1)'(TX_DEPTH);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIVIDER);
  localparam logic [4:0] A_DATA = 5'h00, A_STAT = 5'h04, A_DIVL = 5'h08, A_DIVH = 5'h0C;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [DIV_W-1:0] r_div;
  logic             w_wr_data, w_rd_data, w_rd_stat;
  logic             r_tx_ovf;
  logic             w_rx_avail, w_rx_ovr, w_rx_ferr;
  logic [7:0]       w_rx_head;
  logic [7:0]       w_status, w_rd_mux;

  assign w_wr_data = bus.wr_en && (bus.addr == A_DATA);
  assign w_rd_data = bus.rd_en && (bus.addr == A_DATA);
  assign w_rd_stat = bus.rd_en && (bus.addr == A_STAT);

  always_ff @(posedge clk) begin
    if (!rstn)                                  r_div <= DIV_RST;
    else if (bus.wr_en && bus.addr == A_DIVL)   r_div[7:0] <= bus.wr_data;
    else if (bus.wr_en && bus.addr == A_DIVH)   r_div <= DIV_W'({bus.wr_data, r_div[7:0]});
  end

  // TX FIFO
  logic [7:0]       r_tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] r_tx_wp, r_tx_rp;
  logic [TX_AW:0]   r_tx_cnt;
  logic             w_tx_empty, w_tx_full, w_tx_push, w_tx_pop, w_tx_ovf_set, w_tx_busy;

  state_t           r_tx_state;
  logic [DIV_W-1:0] r_tx_timer, r_tx_bdiv;
  logic [7:0]       r_tx_shift;
  logic [2:0]       r_tx_idx;
  logic             r_tx_line;

  assign w_tx_empty   = (r_tx_cnt == '0);
  assign w_tx_full    = (r_tx_cnt == TX_FULL);
  assign w_tx_pop     = !w_tx_empty &&
                        ((r_tx_state == S_IDLE) || (r_tx_state == S_STOP && r_tx_timer == '0));
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_tx_push    = w_wr_data && (!w_tx_full || w_tx_pop);
  assign w_tx_ovf_set = w_wr_data && w_tx_full && !w_tx_pop;
  assign w_tx_busy    = (r_tx_state != S_IDLE) || !w_tx_empty;
  assign tx           = r_tx_line;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
        2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tx_state <= S_IDLE;
      r_tx_timer <= '0;
      r_tx_bdiv  <= DIV_RST;
      r_tx_shift <= '0;
      r_tx_idx   <= '0;
      r_tx_line  <= 1'b1;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          if (w_tx_pop) begin
            r_tx_shift <= r_tx_mem[r_tx_rp];
            r_tx_bdiv  <= r_div;
            r_tx_timer <= r_div;
            r_tx_line  <= 1'b0;
            r_tx_state <= S_START;
          end
        end
        S_START: begin
          if (r_tx_timer == '0) begin
            r_tx_timer <= r_tx_bdiv;
            r_tx_line  <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_idx   <= '0;
            r_tx_state <= S_DATA;
          end else r_tx_timer <= r_tx_timer - 1'b1;
        end
        S_DATA: begin
          if (r_tx_timer == '0) begin
            r_tx_timer <= r_tx_bdiv;
            if (r_tx_idx == 3'd7) begin
              r_tx_line  <= 1'b1;
              r_tx_state <= S_STOP;
            end else begin
              r_tx_line  <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_tx_idx   <= r_tx_idx + 1'b1;
            end
          end else r_tx_timer <= r_tx_timer - 1'b1;
        end
        S_STOP: begin
          if (r_tx_timer == '0) begin
            if (w_tx_pop) begin
              r_tx_shift <= r_tx_mem[r_tx_rp];
              r_tx_bdiv  <= r_div;
              r_tx_timer <= r_div;
              r_tx_line  <= 1'b0;
              r_tx_state <= S_START;
            end else r_tx_state <= S_IDLE;
          end else r_tx_timer <= r_tx_timer - 1'b1;
        end
        default: r_tx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn)             r_tx_ovf <= 1'b0;
    else if (w_tx_ovf_set) r_tx_ovf <= 1'b1;
    else if (w_rd_stat)    r_tx_ovf <= 1'b0;
  end

`ifdef UART_RX_EN
  localparam int             RX_AW   = $clog2(RX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL = (RX_AW+1)'(RX_DEPTH);

  logic             r_rx_s1, r_rx_s2;
  state_t           r_rx_state;
  logic [DIV_W-1:0] r_rx_timer, r_rx_bdiv, w_rx_half;
  logic [7:0]       r_rx_shift;
  logic [2:0]       r_rx_idx;
  logic [7:0]       r_rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] r_rx_wp, r_rx_rp;
  logic [RX_AW:0]   r_rx_cnt;
  logic             r_rx_ovr, r_rx_ferr;
  logic             w_rx_empty, w_rx_full, w_rx_good, w_rx_bad, w_rx_push, w_rx_pop, w_rx_ovr_set;

  assign w_rx_half    = DIV_W'(({1'b0, r_div} + 1'b1) >> 1);
  assign w_rx_empty   = (r_rx_cnt == '0);
  assign w_rx_full    = (r_rx_cnt == RX_FULL);
  assign w_rx_good    = (r_rx_state == S_STOP) && (r_rx_timer == '0) &&  r_rx_s2;
  assign w_rx_bad     = (r_rx_state == S_STOP) && (r_rx_timer == '0) && !r_rx_s2;
  assign w_rx_pop     = w_rd_data && !w_rx_empty;
  assign w_rx_push    = w_rx_good && (!w_rx_full || w_rx_pop);
  assign w_rx_ovr_set = w_rx_good && w_rx_full && !w_rx_pop;
  assign w_rx_avail   = !w_rx_empty;
  assign w_rx_head    = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp];
  assign w_rx_ovr     = r_rx_ovr;
  assign w_rx_ferr    = r_rx_ferr;

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_shift;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rx_wp   <= '0;
      r_rx_rp   <= '0;
      r_rx_cnt  <= '0;
      r_rx_ovr  <= 1'b0;
      r_rx_ferr <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
      if (w_rx_ovr_set)   r_rx_ovr <= 1'b1;
      else if (w_rd_stat) r_rx_ovr <= 1'b0;
      if (w_rx_bad)       r_rx_ferr <= 1'b1;
      else if (w_rd_stat) r_rx_ferr <= 1'b0;
    end
  end

  // Start detection waits half a bit so every later sample lands mid-bit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_timer <= '0;
      r_rx_bdiv  <= DIV_RST;
      r_rx_shift <= '0;
      r_rx_idx   <= '0;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      case (r_rx_state)
        S_IDLE: begin
          if (!r_rx_s2) begin
            r_rx_bdiv  <= r_div;
            r_rx_timer <= w_rx_half;
            r_rx_state <= S_START;
          end
        end
        S_START: begin
          if (r_rx_timer == '0) begin
            if (r_rx_s2) r_rx_state <= S_IDLE;
            else begin
              r_rx_timer <= r_rx_bdiv;
              r_rx_idx   <= '0;
              r_rx_state <= S_DATA;
            end
          end else r_rx_timer <= r_rx_timer - 1'b1;
        end
        S_DATA: begin
          if (r_rx_timer == '0) begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_timer <= r_rx_bdiv;
            if (r_rx_idx == 3'd7) r_rx_state <= S_STOP;
            else                  r_rx_idx   <= r_rx_idx + 1'b1;
          end else r_rx_timer <= r_rx_timer - 1'b1;
        end
        S_STOP: begin
          if (r_rx_timer == '0) r_rx_state <= S_IDLE;
          else                  r_rx_timer <= r_rx_timer - 1'b1;
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end
`else
  logic w_unused_rx;
  assign w_unused_rx = rx ^ (RX_DEPTH == 0);
  assign w_rx_avail  = 1'b0;
  assign w_rx_ovr    = 1'b0;
  assign w_rx_ferr   = 1'b0;
  assign w_rx_head   = 8'h00;
`endif

  assign w_status = {2'b00, w_rx_ferr, w_rx_ovr, r_tx_ovf, w_rx_avail, w_tx_full, w_tx_busy};

  always_comb begin
    w_rd_mux = 8'h00;
    case (bus.addr)
      A_DATA:  w_rd_mux = w_rx_head;
      A_STAT:  w_rd_mux = w_status;
      A_DIVL:  w_rd_mux = r_div[7:0];
      A_DIVH:  w_rd_mux = 8'(r_div >> 8);
      default: w_rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= 8'h00;
    end else begin
      bus.rd_valid <= bus.rd_en;
      bus.rd_data  <= bus.rd_en ? w_rd_mux : 8'h00;
    end
  end
endmodule

// File: tb/tb_uart_fifo.sv
// Directed self-checking bench for uart_fifo; receiver scenarios compile in with UART_RX_EN.
module tb_uart_fifo;
  logic clk = 1'b0;
  logic rstn;
  logic tx, rx, loop_en, rx_drv;
  int   checks = 0;
  int   failures = 0;

  uart_fifo_if bus();
  assign rx = loop_en ? tx : rx_drv;

  uart_fifo dut (.clk(clk), .rstn(rstn), .bus(bus), .tx(tx), .rx(rx));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk); bus.addr = a; bus.wr_data = d; bus.wr_en = 1'b1;
    @(negedge clk); bus.wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [7:0] d, output logic v);
    @(negedge clk); bus.addr = a; bus.rd_en = 1'b1;
    @(negedge clk); bus.rd_en = 1'b0; d = bus.rd_data; v = bus.rd_valid;
  endtask

  task automatic capture_tx(input int n, output logic [79:0] w);
    w = '0;
    for (int i = 0; i < n; i++) begin @(negedge clk); w[i] = tx; end
  endtask

  // Reference waveform: start, 8 data bits LSB first, stop, each cpb cycles long.
  function automatic logic [79:0] frame_wave(input logic [7:0] d, input int cpb);
    logic [9:0] bits;
    bits = {1'b1, d, 1'b0};
    frame_wave = '0;
    for (int i = 0; i < 10 * cpb; i++) frame_wave[i] = bits[i / cpb];
  endfunction

  task automatic drive_rx(input logic [9:0] bits, input int cpb);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin rx_drv = bits[i]; repeat (cpb) @(negedge clk); end
    rx_drv = 1'b1;
  endtask

  task automatic test_reset;
    logic [7:0] d; logic v;
    rstn = 1'b0; loop_en = 1'b0; rx_drv = 1'b1;
    bus.addr = '0; bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.wr_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
    checks++; if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", bus.rd_data); end
    rstn = 1'b1;
    bus_read(5'h04, d, v);
    checks++; if (d !== 8'h00 || v !== 1'b1) begin failures++; $display("FAIL reset_status got=%h/%b exp=00/1", d, v); end
    @(negedge clk);
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL rd_valid_pulse got=%b exp=0", bus.rd_valid); end
    bus_read(5'h08, d, v);
    checks++; if (d !== 8'h07 || v !== 1'b1) begin failures++; $display("FAIL reset_div_lo got=%h exp=07", d); end
    bus_read(5'h0C, d, v);
    checks++; if (d !== 8'h00 || v !== 1'b1) begin failures++; $display("FAIL reset_div_hi got=%h exp=00", d); end
    bus_read(5'h10, d, v);
    checks++; if (d !== 8'h00 || v !== 1'b1) begin failures++; $display("FAIL unmapped_read got=%h/%b exp=00/1", d, v); end
    bus_write(5'h09, 8'hFF);
    bus_write(5'h0D, 8'hFF);
    bus_read(5'h08, d, v);
    checks++; if (d !== 8'h07) begin failures++; $display("FAIL unmapped_write_lo got=%h exp=07", d); end
    bus_read(5'h0C, d, v);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL unmapped_write_hi got=%h exp=00", d); end
  endtask

  task automatic test_single_frame;
    logic [79:0] w; logic [7:0] d, d2; logic v, v2;
    bus_write(5'h00, 8'h41);
    fork
      capture_tx(80, w);
      begin repeat (10) @(negedge clk); bus_read(5'h04, d2, v2); end
    join
    checks++; if (w !== frame_wave(8'h41, 8)) begin failures++; $display("FAIL frame_41 got=%h exp=%h", w, frame_wave(8'h41, 8)); end
    checks++; if (d2 !== 8'h01) begin failures++; $display("FAIL busy_mid_frame got=%h exp=01", d2); end
    bus_read(5'h04, d, v);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL busy_after_stop got=%h exp=00", d); end
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL idle_tx got=%b exp=1", tx); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b2b [9] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h3C, 8'hC3, 8'h96};
    logic [7:0] d, s_full, s_part; logic v, v1, v2;
    fork
      begin
        for (int i = 0; i < 9; i++) begin
          @(negedge clk); bus.addr = 5'h00; bus.wr_data = b2b[i]; bus.wr_en = 1'b1;
        end
        @(negedge clk); bus.wr_en = 1'b0;
        bus_read(5'h04, s_full, v1);
        repeat (100) @(negedge clk);
        bus_read(5'h04, s_part, v2);
      end
      begin
        logic [79:0] w;
        @(negedge clk); @(negedge clk);
        for (int f = 0; f < 9; f++) begin
          capture_tx(80, w);
          checks++;
          if (w !== frame_wave(b2b[f], 8)) begin
            failures++; $display("FAIL b2b_frame%0d got=%h exp=%h", f, w, frame_wave(b2b[f], 8));
          end
        end
      end
    join
    checks++; if (s_full !== 8'h03) begin failures++; $display("FAIL b2b_full got=%h exp=03", s_full); end
    checks++; if (s_part !== 8'h01) begin failures++; $display("FAIL b2b_not_full got=%h exp=01", s_part); end
    bus_read(5'h04, d, v);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL b2b_done got=%h exp=00", d); end
  endtask

  task automatic test_tx_overflow;
    logic [7:0] d; logic v;
    bus_write(5'h00, 8'hE7);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); bus.addr = 5'h00; bus.wr_data = 8'(i); bus.wr_en = 1'b1;
    end
    @(negedge clk); bus.wr_en = 1'b0;
    bus_read(5'h04, d, v);
    checks++; if (d !== 8'h0B) begin failures++; $display("FAIL ovf_status got=%h exp=0b", d); end
    bus_read(5'h04, d, v);
    checks++; if (d !== 8'h03) begin failures++; $display("FAIL ovf_cleared got=%h exp=03", d); end
    repeat (760) @(negedge clk);
    bus_read(5'h04, d, v);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL ovf_drained got=%h exp=00", d); end
  endtask

  task automatic test_divisor_change;
    logic [79:0] wa, wb; logic [7:0] d; logic v;
    bus_write(5'h00, 8'hA5);
    fork
      begin capture_tx(80, wa); capture_tx(40, wb); end
      begin bus_write(5'h00, 8'h3C); repeat (20) @(negedge clk); bus_write(5'h08, 8'h03); end
    join
    checks++; if (wa !== frame_wave(8'hA5, 8)) begin failures++; $display("FAIL div_old_frame got=%h exp=%h", wa, frame_wave(8'hA5, 8)); end
    checks++; if (wb !== frame_wave(8'h3C, 4)) begin failures++; $display("FAIL div_new_frame got=%h exp=%h", wb, frame_wave(8'h3C, 4)); end
    bus_read(5'h08, d, v);
    checks++; if (d !== 8'h03) begin failures++; $display("FAIL div_readback got=%h exp=03", d); end
    bus_read(5'h04, d, v);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL div_idle got=%h exp=00", d); end
  endtask

  task automatic test_reset_mid_frame;
    logic [79:0] w, exp_w; logic [7:0] d; logic v;
    bus_write(5'h00, 8'h00);
    bus_write(5'h00, 8'hFF);
    repeat (8) @(negedge clk);
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL mid_data_tx got=%b exp=0", tx); end
    rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL rst_abort_tx got=%b exp=1", tx); end
    bus_read(5'h04, d, v);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_status got=%h exp=00", d); end
    bus_read(5'h08, d, v);
    checks++; if (d !== 8'h07) begin failures++; $display("FAIL rst_div got=%h exp=07", d); end
    capture_tx(20, w);
    exp_w = '0;
    for (int i = 0; i < 20; i++) exp_w[i] = 1'b1;
    checks++; if (w !== exp_w) begin failures++; $display("FAIL rst_tx_idle got=%h exp=%h", w, exp_w); end
  endtask

`ifdef UART_RX_EN
  task automatic test_rx_loopback;
    logic [7:0] d; logic v;
    loop_en = 1'b1;
    bus_write(5'h00, 8'h5A);
    repeat (100) @(negedge clk);
    bus_read(5'h04, d, v);
    checks++; if (d !== 8'h04) begin failures++; $display("FAIL rx_avail got=%h exp=04", d); end
    bus_read(5'h00, d, v);
    checks++; if (d !== 8'h5A || v !== 1'b1) begin failures++; $display("FAIL rx_byte got=%h/%b exp=5a/1", d, v); end
    bus_read(5'h04, d, v);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rx_empty_after got=%h exp=00", d); end
    loop_en = 1'b0;
  endtask

  task automatic test_rx_errors;
    logic [7:0] d; logic v;
    drive_rx({1'b0, 8'hC3, 1'b0}, 8);
    repeat (30) @(negedge clk);
    bus_read(5'h04, d, v);
    checks++; if (d !== 8'h20) begin failures++; $display("FAIL rx_ferr got=%h exp=20", d); end
    bus_read(5'h04, d, v);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rx_ferr_clear got=%h exp=00", d); end
    bus_read(5'h00, d, v);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rx_ferr_nobyte got=%h exp=00", d); end
    @(negedge clk); rx_drv = 1'b0;
    repeat (2) @(negedge clk); rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(5'h04, d, v);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rx_glitch got=%h exp=00", d); end
  endtask
`else
  task automatic test_rx_absent;
    logic [7:0] d; logic v;
    drive_rx({1'b1, 8'h5A, 1'b0}, 8);
    repeat (30) @(negedge clk);
    bus_read(5'h04, d, v);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL norx_status got=%h exp=00", d); end
    bus_read(5'h00, d, v);
    checks++; if (d !== 8'h00 || v !== 1'b1) begin failures++; $display("FAIL norx_read got=%h/%b exp=00/1", d, v); end
  endtask
`endif

  initial begin
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_tx_overflow;
    test_divisor_change;
    test_reset_mid_frame;
`ifdef UART_RX_EN
    test_rx_loopback;
    test_rx_errors;
`else
    test_rx_absent;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
